// File: rtl/fir_mac_serial.sv
// Coefficient-loadable FIR filter built around one time-multiplexed signed MAC.
// One sample is accepted per TAPS+2 cycles; each result is shifted, saturated and strobed out.
module fir_mac_serial #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ENABLE,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] input_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  output_data,
  output logic signed [DATA_W-1:0] sampleT,
  output logic                     busy,
  output logic                     overflow
);

  localparam int IDX_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic [IDX_W-1:0]         r_tap;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DATA_W-1:0] r_x [TAPS];
  logic signed [COEF_W-1:0] r_h [TAPS];
  logic                     r_out_valid;
  logic signed [OUT_W-1:0]  r_out;
  logic signed [DATA_W-1:0] r_sample;
  logic                     r_overflow;

  logic                     w_accept;
  logic                     w_addr_ok;
  logic                     w_coef_wr;
  logic                     w_last_tap;
  logic signed [DATA_W-1:0] w_x_sel;
  logic signed [COEF_W-1:0] w_h_sel;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_shifted;
  logic                     w_pos_clip;
  logic                     w_neg_clip;
  logic signed [OUT_W-1:0]  w_sat;

  assign in_ready   = !RST && (r_state == S_IDLE) && ENABLE;
  assign w_accept   = in_ready && in_valid;
  assign w_addr_ok  = ({1'b0, coef_addr} < (IDX_W + 1)'(TAPS));
  // Coefficients are frozen while a sample is in flight, whatever ENABLE does.
  assign w_coef_wr  = coef_we && (r_state == S_IDLE) && w_addr_ok;
  assign w_last_tap = (r_tap == IDX_W'(TAPS - 1));

  assign w_x_sel    = r_x[r_tap];
  assign w_h_sel    = r_h[r_tap];
  assign w_prod     = $signed({{COEF_W{w_x_sel[DATA_W-1]}}, w_x_sel})
                    * $signed({{DATA_W{w_h_sel[COEF_W-1]}}, w_h_sel});
  assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};

  assign w_shifted  = r_acc >>> SHIFT;
  assign w_pos_clip = !w_shifted[ACC_W-1] && (|w_shifted[ACC_W-1:OUT_W-1]);
  assign w_neg_clip = w_shifted[ACC_W-1] && !(&w_shifted[ACC_W-1:OUT_W-1]);

  // NOTE: w_sat gets its default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    w_sat = w_shifted[OUT_W-1:0];
    if (w_pos_clip) begin
      w_sat = {1'b0, {(OUT_W - 1){1'b1}}};
    end else if (w_neg_clip) begin
      w_sat = {1'b1, {(OUT_W - 1){1'b0}}};
    end
  end

  // NOTE: the delay line and coefficient bank must read as zero after reset, so they are
  // reset flops rather than a RAM macro.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
        r_h[k] <= '0;
      end
    end else begin
      if (w_coef_wr) begin
        r_h[coef_addr] <= coef_data;
      end
      if (w_accept) begin
        r_x[0] <= input_data;
        for (int k = 1; k < TAPS; k++) begin
          r_x[k] <= r_x[k-1];
        end
      end
    end
  end

  // NOTE: every register here uses <=, so all branches see pre-edge values of r_acc and r_tap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_tap       <= '0;
      r_acc       <= '0;
      r_out       <= '0;
      r_sample    <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (ENABLE) begin
        unique case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_sample <= input_data;
              r_acc    <= '0;
              r_tap    <= '0;
              r_state  <= S_MAC;
            end
          end
          S_MAC: begin
            r_acc <= r_acc + w_prod_ext;
            if (w_last_tap) begin
              r_tap   <= '0;
              r_state <= S_DONE;
            end else begin
              r_tap <= r_tap + IDX_W'(1);
            end
          end
          S_DONE: begin
            r_out       <= w_sat;
            r_out_valid <= 1'b1;
            if (w_pos_clip || w_neg_clip) begin
              r_overflow <= 1'b1;
            end
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign output_data = r_out;
  assign sampleT     = r_sample;
  assign busy        = (r_state != S_IDLE);
  assign overflow    = r_overflow;

endmodule

// File: doc/fir_mac_serial.md
Name: fir_mac_serial

Overview:
Parametrised, coefficient-loadable FIR filter. It replaces the fixed fir_filter with one time-multiplexed signed multiply-accumulate unit, and adds a valid/ready input handshake, an output valid strobe, runtime coefficient writes, and output scaling with saturation. It sits in the same sample path as fir_filter, keeps the CLK/RST/ENABLE/input_data/output_data/sampleT port set, and adds handshake and configuration ports.

Parameters:
DATA_W, 16, sample width (signed two's complement)
COEF_W, 16, coefficient width (signed)
TAPS, 8, number of taps (>=2); delay line depth and MAC cycles per sample
ACC_W, 40, accumulator width; must be >= DATA_W+COEF_W+clog2(TAPS)
OUT_W, 32, output width (signed, <= ACC_W)
SHIFT, 0, arithmetic right shift applied to the accumulator before saturation

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-high
ENABLE  input  1  global run enable; low freezes all state except coefficient writes
in_valid  input  1  input_data is valid
in_ready  output  1  block can accept a sample
input_data  input  DATA_W  input sample
coef_we  input  1  coefficient write strobe
coef_addr  input  clog2(TAPS)  coefficient index (0 = newest sample's tap)
coef_data  input  COEF_W  coefficient value
out_valid  output  1  one-cycle strobe; output_data holds a new result
output_data  output  OUT_W  filtered output; held between strobes
sampleT  output  DATA_W  last accepted sample
busy  output  1  high in MAC or DONE
overflow  output  1  sticky; set when a result saturates

Behaviour:
- Reset (async, RST=1) clears:
  - delay line x[0..TAPS-1] and all coefficients h[0..TAPS-1] to 0
  - accumulator and tap index to 0
  - output_data, sampleT, out_valid, overflow, busy to 0
  - FSM to IDLE
- On reset release, in_ready=1 as soon as ENABLE=1.
- FSM states:
  - IDLE: in_ready = ENABLE. Accept occurs on a rising edge with in_valid & in_ready:
    - x[k] <= x[k-1] for k>0; x[0] <= input_data
    - sampleT <= input_data; acc <= 0; tap index <= 0
    - go to MAC
  - MAC: in_ready=0. Each enabled cycle:
    - acc += sign_ext(x[i]*h[i]) to ACC_W, using the full DATA_W+COEF_W product; i++
    - after i=TAPS-1, go to DONE
    - ENABLE=0 holds state, acc and i unchanged
  - DONE: in_ready=0.
    - r = acc >>> SHIFT
    - output_data <= r clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
    - if clamped, overflow <= 1
    - out_valid=1 for exactly this one cycle; go to IDLE
- Latency: sample accepted at edge E; out_valid high in the cycle following edge E+TAPS+1, assuming ENABLE stays high.
- Throughput: one sample per TAPS+2 cycles.
- Coefficient writes (coef_we high on an edge, h[coef_addr] <= coef_data):
  - In IDLE, applied regardless of ENABLE.
  - In MAC or DONE, ignored, so no mid-computation change.
  - A write and a sample accept on the same edge: the write lands, and the new coefficient is used by that sample's MAC.
  - coef_addr >= TAPS: write ignored.
- Accumulator wraps modulo 2^ACC_W; the ACC_W rule above guarantees no wrap.
- in_valid while in_ready=0: sample not taken; the upstream holds it.
- overflow clears only on RST.
- RST asserted mid-MAC: the computation is aborted and no out_valid is issued.

Test Plan:
- Impulse: load h = 1..8, feed 1 then seven 0s (TAPS=8) -> output_data sequence 1,2,3,4,5,6,7,8; each out_valid arrives TAPS+1 edges after its accept; overflow=0.
- Latency/handshake: in_valid held high continuously -> in_ready pulses once per 10 cycles; exactly one out_valid per accepted sample; sampleT tracks each accepted sample.
- Saturation (OUT_W=16, SHIFT=0): all h = 0x0100, eight inputs 0x0100 -> 0x7FFF, overflow=1. Eight inputs 0xFF00 -> 0x8000.
- Scaling: SHIFT=8, all h = 0x0100, input 0x0003 steady -> final output 24.
- Freeze/coef guard: drop ENABLE for 5 cycles mid-MAC and write coef_addr=0 during MAC -> result delayed by exactly 5 cycles, value identical to the unfrozen run, h[0] unchanged.
- Reset mid-MAC: assert RST at MAC tap 3 -> all outputs 0, no out_valid. A fresh impulse after reset gives all-zero output (coefficients cleared).
